// File: rtl/huff_bit_feeder.sv
// Bit-window feeder for a Huffman decoder: packs 32-bit compressed words into a
// 64-bit left-aligned shift buffer and retires variable-length codes from the top.
module huff_bit_feeder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] total_bits,
  input  logic [31:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic [31:0]      data,
  output logic             buf_valid,
  input  logic [5:0]       len,
  input  logic             len_valid,
  output logic             done,
  output logic             err,
  output logic             idle
);

  localparam int unsigned BUF_W  = 64;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned FILL_W = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [BUF_W-1:0]   buffer, buffer_n;
  logic [FILL_W-1:0]  fill, fill_n;
  logic [CNT_W-1:0]   bits_left, bits_left_n;
  logic [CNT_W-1:0]   words_left, words_left_n;
  logic               err_q, err_n;

  logic [CNT_W-1:0]   len_ext;
  logic [CNT_W:0]     total_round;
  logic [CNT_W-1:0]   words_init;
  logic               consume_req;
  logic               len_ok;
  logic               consume;
  logic               bad_len;
  logic               xfer;
  logic [FILL_W-1:0]  consumed;
  logic [FILL_W-1:0]  fill_after;

  // Status outputs decode registered state only; nothing depends on len.
  assign word_ready = ((state == S_PRIME) || (state == S_RUN)) &&
                      (fill <= FILL_W'(WORD_W)) && (words_left != '0);
  assign buf_valid  = (state == S_RUN) &&
                      ((fill >= FILL_W'(WORD_W)) ||
                       ((words_left == '0) && (bits_left != '0)));
  assign data       = buffer[BUF_W-1 -: WORD_W];
  assign done       = (state == S_DONE);
  assign idle       = (state == S_IDLE);
  assign err        = err_q;

  assign len_ext     = CNT_W'(len);
  assign total_round = {1'b0, total_bits} + (CNT_W+1)'(WORD_W - 1);
  assign words_init  = CNT_W'(total_round >> 5);

  // A code is retired only when it fits in the window and in the stream.
  assign consume_req = len_valid && buf_valid && (len != '0);
  assign len_ok      = (len <= 6'(WORD_W)) && (len_ext <= bits_left);
  assign consume     = consume_req && len_ok;
  assign bad_len     = consume_req && !len_ok;
  assign xfer        = word_valid && word_ready;
  assign consumed    = consume ? FILL_W'(len) : '0;
  assign fill_after  = fill - consumed;

  always_comb begin
    state_n      = state;
    buffer_n     = buffer << consumed;
    fill_n       = fill_after;
    bits_left_n  = consume ? (bits_left - len_ext) : bits_left;
    words_left_n = words_left;
    err_n        = err_q || bad_len;

    // New word lands directly below the bits that survive this cycle's shift.
    if (xfer) begin
      buffer_n     = buffer_n | (BUF_W'({word_in, 32'h0}) >> fill_after);
      fill_n       = fill_after + FILL_W'(WORD_W);
      words_left_n = words_left - CNT_W'(1);
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          bits_left_n  = total_bits;
          words_left_n = words_init;
          fill_n       = '0;
          buffer_n     = '0;
          err_n        = 1'b0;
          state_n      = (total_bits == '0) ? S_DONE : S_PRIME;
        end
      end
      S_PRIME: begin
        if ((fill >= FILL_W'(WORD_W)) || (words_left == '0)) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (consume && (bits_left_n == '0)) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      buffer     <= '0;
      fill       <= '0;
      bits_left  <= '0;
      words_left <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      buffer     <= buffer_n;
      fill       <= fill_n;
      bits_left  <= bits_left_n;
      words_left <= words_left_n;
      err_q      <= err_n;
    end
  end

endmodule
